// File: rtl/encoder8_arbiter_if.sv
// Request/grant bundle between the requesters and the encoder8 arbiter.
// Signals:
//   dis       block new grants (1 = blocked)
//   req_n     8 active-low requests, bit i = requester i
//   done      one-cycle release pulse from the granted requester
//   gnt_valid high while a grant is held
//   gnt_id    granted index, 3'b111 when idle
//   gnt_n     active-low one-hot grant, 8'hFF when idle
//   timeout   one-cycle pulse when a grant ended by hold expiry
// Modports:
//   master  requester side, drives requests and observes grants
//   slave   arbiter side
interface encoder8_arbiter_if;
  logic       dis;
  logic [7:0] req_n;
  logic       done;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic [7:0] gnt_n;
  logic       timeout;

  modport master (
    output dis, req_n, done,
    input  gnt_valid, gnt_id, gnt_n, timeout
  );

  modport slave (
    input  dis, req_n, done,
    output gnt_valid, gnt_id, gnt_n, timeout
  );
endinterface

// File: rtl/encoder8_arbiter.sv
// Round-robin arbiter sharing one 8-to-3 encoder slot among 8 active-low requesters.
// Latency: a request present at a clock edge is granted by that edge (1 cycle); after a
// release there is one dead cycle before the next grant can be issued.
// Backpressure: dis blocks new grants only; a held grant runs until done, withdrawal or MAX_HOLD.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   encoder8_arbiter_if.slave (dis, req_n, done in; gnt_valid, gnt_id, gnt_n, timeout out)
module encoder8_arbiter #(
  parameter int MAX_HOLD = 16  // max cycles a grant may be held; 0 = no timeout
) (
  input logic               clk,
  input logic               rst,
  encoder8_arbiter_if.slave bus
);

  // Hold counter is sized so MAX_HOLD-1 fits; a zero MAX_HOLD still needs a legal 1-bit vector.
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]    state;
  logic [2:0]    last;
  logic [CW-1:0] cnt;

  logic [2:0]    winner;
  logic          any_req;
  logic          rel_done;
  logic          rel_wd;
  logic          rel_tmo;

  // Rotating-priority search: start one past the last winner and wrap; the
  // previous winner itself is considered last (offset 8 wraps to offset 0).
  always_comb begin
    winner  = last;
    any_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!any_req && !bus.req_n[last + 3'(i)]) begin
        winner  = last + 3'(i);
        any_req = 1'b1;
      end
    end
  end

  assign rel_done = bus.done;
  assign rel_wd   = bus.req_n[bus.gnt_id];
  assign rel_tmo  = (MAX_HOLD != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last          <= 3'd7;
      cnt           <= '0;
      bus.gnt_valid <= 1'b0;
      bus.gnt_id    <= 3'b111;
      bus.gnt_n     <= 8'hFF;
      bus.timeout   <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.dis && any_req) begin
            state         <= GRANT;
            bus.gnt_valid <= 1'b1;
            bus.gnt_id    <= winner;
            bus.gnt_n     <= ~(8'd1 << winner);
            last          <= winner;
            cnt           <= '0;
          end
        end
        GRANT: begin
          if (rel_done || rel_wd || rel_tmo) begin
            state         <= GAP;
            bus.gnt_valid <= 1'b0;
            bus.gnt_id    <= 3'b111;
            bus.gnt_n     <= 8'hFF;
            // Expiry is only reported when neither done nor withdrawal also ended the grant.
            bus.timeout   <= rel_tmo && !rel_done && !rel_wd;
          end else if (MAX_HOLD != 0) begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder8_arbiter.sv
// Self-checking bench for encoder8_arbiter: directed vector table, round-robin wrap,
// asynchronous mid-grant reset, then randomized traffic against a behavioural model.
module tb_encoder8_arbiter;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  encoder8_arbiter_if bus ();

  encoder8_arbiter #(.MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Outputs packed as {gnt_valid, gnt_id, gnt_n, timeout}.
  function automatic logic [12:0] outs();
    return {bus.gnt_valid, bus.gnt_id, bus.gnt_n, bus.timeout};
  endfunction

  function automatic logic [12:0] granted(input int id);
    logic [7:0] oh;
    oh = 8'd1 << id;
    return {1'b1, 3'(id), ~oh, 1'b0};
  endfunction

  function automatic logic [12:0] idle(input logic t);
    return {1'b0, 3'b111, 8'hFF, t};
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got vld=%0b id=%0d gnt_n=%h tmo=%0b, want vld=%0b id=%0d gnt_n=%h tmo=%0b",
               name, act[12], act[11:9], act[8:1], act[0], exp[12], exp[11:9], exp[8:1], exp[0]);
    end
  endtask

  // Behavioural model: who owns the slot, how long it has been visible,
  // a one-cycle cooldown after each release, and the round-robin pointer.
  int m_owner;
  int m_age;
  int m_cool;
  int m_last;
  bit m_tmo;

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_cool  = 0;
    m_last  = 7;
    m_tmo   = 1'b0;
  endtask

  task automatic model_step();
    m_tmo = 1'b0;
    if (m_owner >= 0) begin
      m_age++;
      if (bus.done || bus.req_n[m_owner] || (MH != 0 && m_age == MH)) begin
        m_tmo   = !bus.done && !bus.req_n[m_owner];
        m_owner = -1;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool = 0;
    end else if (!bus.dis && bus.req_n != 8'hFF) begin
      for (int k = 1; k <= 8; k++) begin
        if (m_owner < 0 && !bus.req_n[(m_last + k) % 8]) m_owner = (m_last + k) % 8;
      end
      m_last = m_owner;
      m_age  = 0;
    end
  endtask

  function automatic logic [12:0] model_exp();
    return (m_owner >= 0) ? granted(m_owner) : idle(m_tmo);
  endfunction

  // One active edge, then settle to the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.dis   = 1'b0;
    bus.req_n = 8'hFF;
    bus.done  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        dis;
    logic [7:0]  req_n;
    logic        done;
    logic [12:0] exp;
  } vec_t;

  vec_t       tbl [27];
  logic [7:0] onehot;

  initial begin
    tbl[0]  = '{1'b0, 8'hFE, 1'b0, granted(0)};
    tbl[1]  = '{1'b0, 8'hFE, 1'b1, idle(1'b0)};
    tbl[2]  = '{1'b0, 8'hFE, 1'b0, idle(1'b0)};
    tbl[3]  = '{1'b0, 8'hFE, 1'b0, granted(0)};
    tbl[4]  = '{1'b0, 8'hF9, 1'b0, idle(1'b0)};   // requester 0 withdrew
    tbl[5]  = '{1'b0, 8'hF9, 1'b0, idle(1'b0)};
    tbl[6]  = '{1'b0, 8'hF9, 1'b0, granted(1)};
    tbl[7]  = '{1'b0, 8'hF9, 1'b0, granted(1)};
    tbl[8]  = '{1'b0, 8'hF9, 1'b0, granted(1)};
    tbl[9]  = '{1'b0, 8'hF9, 1'b0, granted(1)};
    tbl[10] = '{1'b0, 8'hF9, 1'b0, idle(1'b1)};   // held exactly MH cycles
    tbl[11] = '{1'b0, 8'hF9, 1'b0, idle(1'b0)};
    tbl[12] = '{1'b0, 8'hF9, 1'b0, granted(2)};
    tbl[13] = '{1'b0, 8'hF9, 1'b1, idle(1'b0)};
    tbl[14] = '{1'b1, 8'h7F, 1'b0, idle(1'b0)};
    tbl[15] = '{1'b1, 8'h7F, 1'b0, idle(1'b0)};   // blocked
    tbl[16] = '{1'b0, 8'h7F, 1'b0, granted(7)};
    tbl[17] = '{1'b1, 8'h7F, 1'b0, granted(7)};   // dis does not abort
    tbl[18] = '{1'b1, 8'h7F, 1'b1, idle(1'b0)};
    tbl[19] = '{1'b1, 8'h7F, 1'b0, idle(1'b0)};
    tbl[20] = '{1'b1, 8'h7F, 1'b0, idle(1'b0)};
    tbl[21] = '{1'b0, 8'hDF, 1'b0, granted(5)};
    tbl[22] = '{1'b0, 8'hDF, 1'b0, granted(5)};
    tbl[23] = '{1'b0, 8'hDF, 1'b0, granted(5)};
    tbl[24] = '{1'b0, 8'hDF, 1'b0, granted(5)};
    tbl[25] = '{1'b0, 8'hDF, 1'b1, idle(1'b0)};   // done with expiry: no pulse
    tbl[26] = '{1'b0, 8'hDF, 1'b0, idle(1'b0)};

    do_reset();
    chk("reset_state", outs(), idle(1'b0));

    for (int i = 0; i < 27; i++) begin
      bus.dis   = tbl[i].dis;
      bus.req_n = tbl[i].req_n;
      bus.done  = tbl[i].done;
      tick();
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Round-robin wrap with all requesters active.
    do_reset();
    bus.req_n = 8'h00;
    for (int k = 0; k < 9; k++) begin
      int n;
      n = 0;
      while (!bus.gnt_valid && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("rr_wrap%0d", k), outs(), granted(k % 8));
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    bus.req_n = 8'hDF;
    tick();
    chk("pre_rst_grant", outs(), granted(5));
    tick();
    #2 rst = 1'b1;
    #1 chk("rst_mid_grant", outs(), idle(1'b0));
    model_reset();
    bus.req_n = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_ptr", outs(), granted(0));

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int mode;
      mode = $urandom_range(0, 9);
      if (mode == 0) bus.req_n = 8'hFF;
      else if (mode <= 2) bus.req_n = 8'($urandom);
      else if (mode == 3) begin
        onehot    = 8'd1 << $urandom_range(0, 7);
        bus.req_n = ~onehot;
      end
      bus.dis  = ($urandom_range(0, 7) == 0);
      bus.done = ($urandom_range(0, 5) == 0);
      tick();
      chk($sformatf("random%0d", c), outs(), model_exp());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
